// File: rtl/mcs4_pkg.sv
// Shared MCS-4 types used by the i4002 debug bridge.
package mcs4;
  typedef logic [3:0] char_t;
endpackage

// File: rtl/mcs4_ram_dbg_bridge_if.sv
// Host-side request/response stream of the i4002 debug bridge.
interface mcs4_ram_dbg_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_count;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_count
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, err_count
  );
endinterface

// File: rtl/mcs4_ram_dbg_bridge.sv
// Host-side master for the i4002 debug port: one request at a time, one
// strobe to every RAM chip, one response per request with timeout detection.
module mcs4_ram_dbg_bridge #(
  parameter int unsigned NUM_RAMS = 4,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  mcs4_ram_dbg_bridge_if.slave          host,
  output mcs4::char_t [2:0]             dbg_addr,
  output logic [7:0]                    dbg_wdata,
  output logic                          dbg_wen,
  output logic                          dbg_ren,
  input  logic [NUM_RAMS-1:0][7:0]      dbg_rdata,
  input  logic [NUM_RAMS-1:0]           dbg_rdata_vld
);

  localparam int unsigned     TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [11:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          hit;
  logic          multi;
  logic [7:0]    sel_data;

  // Responder scan: lowest-index valid chip wins, any second valid flags a conflict.
  always_comb begin
    hit      = 1'b0;
    multi    = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_RAMS; i++) begin
      if (dbg_rdata_vld[i]) begin
        if (!hit) begin
          hit      = 1'b1;
          sel_data = dbg_rdata[i];
        end else begin
          multi = 1'b1;
        end
      end
    end
  end

  // Next-state and datapath; strobes are registered so they are high exactly in ISSUE.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    timer_d     = timer_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    unique case (state_q)
      IDLE: begin
        if (host.req_valid) begin
          addr_d  = host.req_addr;
          wdata_d = host.req_wdata;
          wen_d   = host.req_write;
          ren_d   = !host.req_write;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wen_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (hit) begin
          rdata_d = sel_data;
          err_d   = multi;
          state_d = RESP;
        end else if (timer_q == TMAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (host.rsp_ready) begin
          state_d = IDLE;
          if (err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      timer_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      timer_q     <= timer_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign host.req_ready = (state_q == IDLE);
  assign host.rsp_valid = (state_q == RESP);
  assign host.rsp_rdata = rdata_q;
  assign host.rsp_err   = err_q;
  assign host.err_count = err_count_q;
  assign dbg_addr       = addr_q;
  assign dbg_wdata      = wdata_q;
  assign dbg_wen        = wen_q;
  assign dbg_ren        = ren_q;

endmodule
